// File: rtl/fetch_mem_arbiter_if.sv
// Bundle of the requester handshakes, the byte-memory read port and the busy flag.
// The arbiter connects through slave; the requesters and memory connect through master.
interface fetch_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16
) ();
  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_ack;
  logic [31:0]           if_data;
  logic                  dm_req;
  logic [31:0]           dm_addr;
  logic                  dm_ack;
  logic [31:0]           dm_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [7:0]            mem_rdata;
  logic                  busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_addr, mem_rdata,
    output if_ack, if_data, dm_ack, dm_data, mem_addr, mem_rd, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_addr, mem_rdata,
    input  if_ack, if_data, dm_ack, dm_data, mem_addr, mem_rd, busy
  );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory read port between instruction
// fetch and data load; each grant reads four bytes into a big-endian word.
module fetch_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  fetch_mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W  = 2;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic                  gnt_dm_q, gnt_dm_d;   // 1: current grant belongs to data load
  logic                  last_dm_q, last_dm_d; // 1: most recent completed grant was data
  logic                  if_ack_q, if_ack_d;
  logic                  dm_ack_q, dm_ack_d;
  logic [WORD_W-1:0]     if_data_q, if_data_d;
  logic [WORD_W-1:0]     dm_data_q, dm_data_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  busy_q, busy_d;
  logic [WORD_W-1:0]     word_shift;

  // Request-address bits above the memory width are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_WIDTH], bus.dm_addr[31:ADDR_WIDTH]};

  assign word_shift = {word_q[WORD_W-9:0], bus.mem_rdata};

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      gnt_dm_q   <= 1'b0;
      last_dm_q  <= 1'b1;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_data_q  <= '0;
      dm_data_q  <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      gnt_dm_q   <= gnt_dm_d;
      last_dm_q  <= last_dm_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_data_q  <= if_data_d;
      dm_data_q  <= dm_data_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    gnt_dm_d   = gnt_dm_q;
    last_dm_d  = last_dm_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_data_d  = if_data_q;
    dm_data_d  = dm_data_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          // On contention the requester not served last wins.
          gnt_dm_d   = (bus.if_req && bus.dm_req) ? ~last_dm_q : bus.dm_req;
          mem_addr_d = gnt_dm_d ? bus.dm_addr[ADDR_WIDTH-1:0]
                                : bus.if_addr[ADDR_WIDTH-1:0];
          cnt_d      = '0;
          mem_rd_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        word_d = word_shift;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(3)) begin
          // Publish the word so it is valid alongside the ack during DONE.
          mem_rd_d = 1'b0;
          state_d  = DONE;
          if (gnt_dm_q) begin
            dm_data_d = word_shift;
            dm_ack_d  = 1'b1;
          end else begin
            if_data_d = word_shift;
            if_ack_d  = 1'b1;
          end
        end else begin
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        end
      end
      DONE: begin
        last_dm_d = gnt_dm_q;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.if_ack   = if_ack_q;
  assign bus.dm_ack   = dm_ack_q;
  assign bus.if_data  = if_data_q;
  assign bus.dm_data  = dm_data_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed self-checking bench for fetch_mem_arbiter: a behavioural byte memory
// answers the read port while scripted requests are checked cycle by cycle.
module tb_fetch_mem_arbiter;

  localparam int unsigned AW = 16;

  logic clk;
  logic rst;
  logic [7:0] mem [0:(1<<AW)-1];
  int checks;
  int errors;

  fetch_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.mem_rdata = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in the cycle a request is first visible (cycle 0); returns in the ack cycle (cycle 5).
  task automatic xact(input bit is_dm, input logic [15:0] base, input logic [31:0] exp,
                      input bit mid_change, input string tag);
    logic [15:0] ea;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (mid_change && k == 2) begin
        bus.if_addr = 32'h0000_0100;
        bus.if_req  = 1'b0;
      end
      ea = base + 16'(k - 1);
      chk({tag, "_rd"},   32'(bus.mem_rd),   32'd1);
      chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(ea));
      chk({tag, "_busy"}, 32'(bus.busy),     32'd1);
      chk({tag, "_acks"}, 32'({bus.if_ack, bus.dm_ack}), 32'd0);
    end
    tick();
    chk({tag, "_ifack"}, 32'(bus.if_ack), 32'(!is_dm));
    chk({tag, "_dmack"}, 32'(bus.dm_ack), 32'(is_dm));
    chk({tag, "_data"},  is_dm ? bus.dm_data : bus.if_data, exp);
    chk({tag, "_rd5"},   32'(bus.mem_rd), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h12; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h56; mem[16'h0013] = 8'h78;
    mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h02; mem[16'h0002] = 8'h03; mem[16'h0003] = 8'h04;
    mem[16'h0100] = 8'hDE; mem[16'h0101] = 8'hAD; mem[16'h0102] = 8'hBE; mem[16'h0103] = 8'hEF;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0; bus.dm_addr = '0;
    rst = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_ifack",  32'(bus.if_ack),   32'd0);
    chk("rst_dmack",  32'(bus.dm_ack),   32'd0);
    chk("rst_ifdata", bus.if_data,       32'd0);
    chk("rst_dmdata", bus.dm_data,       32'd0);
    chk("rst_rd",     32'(bus.mem_rd),   32'd0);
    chk("rst_addr",   32'(bus.mem_addr), 32'd0);
    chk("rst_busy",   32'(bus.busy),     32'd0);
    rst = 1'b0;
    tick();

    // Single fetch
    bus.if_addr = 32'h0000_0010; bus.if_req = 1'b1;
    xact(1'b0, 16'h0010, 32'h1234_5678, 1'b0, "fetch");
    bus.if_req = 1'b0;
    tick();
    chk("fetch_idle_busy", 32'(bus.busy), 32'd0);
    chk("fetch_ack_once",  32'(bus.if_ack), 32'd0);

    // Simultaneous requests after reset: fetch first, then data at cycle 11
    rst = 1'b1; tick(); rst = 1'b0; tick();
    bus.if_addr = 32'h0; bus.dm_addr = 32'h0000_0100;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    xact(1'b0, 16'h0000, 32'h0102_0304, 1'b0, "both_i");
    bus.if_req = 1'b0;
    tick();
    chk("both_gap_busy", 32'(bus.busy), 32'd0);
    xact(1'b1, 16'h0100, 32'hDEAD_BEEF, 1'b0, "both_d");
    bus.dm_req = 1'b0;
    tick();

    // Sustained contention: I, D, I, D
    bus.if_addr = 32'h0000_0010; bus.dm_addr = 32'h0000_0100;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    xact(1'b0, 16'h0010, 32'h1234_5678, 1'b0, "rr1_i");
    tick();
    xact(1'b1, 16'h0100, 32'hDEAD_BEEF, 1'b0, "rr2_d");
    tick();
    xact(1'b0, 16'h0010, 32'h1234_5678, 1'b0, "rr3_i");
    tick();
    xact(1'b1, 16'h0100, 32'hDEAD_BEEF, 1'b0, "rr4_d");
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    tick();

    // Wrap and upper-bit masking
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB; mem[16'h0000] = 8'hCC; mem[16'h0001] = 8'hDD;
    bus.dm_addr = 32'hABCD_FFFE; bus.dm_req = 1'b1;
    xact(1'b1, 16'hFFFE, 32'hAABB_CCDD, 1'b0, "wrap");
    bus.dm_req = 1'b0;
    tick();

    // Address change and request drop mid-transaction
    bus.if_addr = 32'h0000_0010; bus.if_req = 1'b1;
    xact(1'b0, 16'h0010, 32'h1234_5678, 1'b1, "drop");
    tick();
    tick();
    chk("drop_no_second_busy", 32'(bus.busy),   32'd0);
    chk("drop_no_second_rd",   32'(bus.mem_rd), 32'd0);

    // Reset on cycle 3 of a read
    bus.if_addr = 32'h0000_0010; bus.if_req = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",   32'(bus.busy),   32'd0);
    chk("mid_rst_rd",     32'(bus.mem_rd), 32'd0);
    chk("mid_rst_ifack",  32'(bus.if_ack), 32'd0);
    chk("mid_rst_ifdata", bus.if_data,     32'd0);
    chk("mid_rst_dmdata", bus.dm_data,     32'd0);
    tick();
    rst = 1'b0;
    xact(1'b0, 16'h0010, 32'h1234_5678, 1'b0, "restart");
    bus.if_req = 1'b0;
    tick();
    chk("end_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_mem_arbiter.md
# fetch_mem_arbiter

Shares one byte-wide, single-ported memory read port between the instruction-fetch requester and the data-load requester. Each granted request is turned into four consecutive byte reads, assembled into a big-endian 32-bit word: the byte at the base address becomes bits [31:24]. The block sits between the datapath and the byte-array memory. It arbitrates round-robin when both requesters contend.

## Interface
- ADDR_WIDTH, 16, memory byte-address width; upper request-address bits are ignored

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- if_req  input  1  instruction-fetch request; level, held until if_ack
- if_addr  input  32  instruction byte address
- if_ack  output  1  one-cycle pulse: if_data valid
- if_data  output  32  assembled instruction word, held until the next if transaction completes
- dm_req  input  1  data-load request; level, held until dm_ack
- dm_addr  input  32  data byte address
- dm_ack  output  1  one-cycle pulse: dm_data valid
- dm_data  output  32  assembled data word, held until the next dm transaction completes
- mem_addr  output  ADDR_WIDTH  byte address to memory
- mem_rd  output  1  read strobe; mem_addr is meaningful while high
- mem_rdata  input  8  memory byte, combinational from mem_addr, valid the same cycle
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, READ, DONE.
- **IDLE**
  - If either request is high, grant one requester.
  - Latch `{grant_id, base = addr[ADDR_WIDTH-1:0]}`, clear cnt, go to READ.
- **Arbitration**
  - Single request: grant it.
  - Both high: grant the requester not granted last.
  - The last-grant register resets to "data", so instruction fetch wins the first contention.
- **READ**
  - mem_rd=1; mem_addr = (base + cnt) mod 2^ADDR_WIDTH.
  - At each clock edge: word <= {word[23:0], mem_rdata}; cnt <= cnt+1.
  - After the edge with cnt=3, go to DONE.
- **DONE**
  - Copy word to if_data or dm_data, according to grant_id.
  - Pulse the matching ack for exactly one cycle; update last_grant.
  - Go to IDLE.
- Addresses are sampled only at grant. Later changes to if_addr/dm_addr are ignored.
- A request dropped mid-transaction does not abort it. The transaction completes and the ack still pulses.
- A requester that keeps req high in the cycle after its ack has made a new request. That request is arbitrated normally, and a waiting peer wins it.
- Unaligned addresses are legal; no alignment check is made.
- Wrap: base 0xFFFE with ADDR_WIDTH=16 reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset values:
  - State IDLE, cnt=0, word=0, last_grant=data.
  - if_ack=0, dm_ack=0, if_data=0, dm_data=0.
  - mem_rd=0, mem_addr=0, busy=0.
- Reset mid-transaction: the FSM returns to IDLE immediately.
  - No ack is issued.
  - if_data/dm_data clear to 0.
  - A request still high after reset release is re-arbitrated from scratch.

## Timing
- Cycle 0: IDLE, request sampled at the end of the cycle.
- Cycles 1–4: READ, mem_rd=1, byte offsets +0..+3.
- Cycle 5: DONE, ack=1, data valid.
- Cycle 6: IDLE, next grant possible at its end.
- Latency is 5 cycles from the request-sampling edge to ack. Peak throughput is one word per 6 cycles.
- mem_addr/mem_rd are driven from registered state only, with no combinational path from the req inputs.
- With both requesters continuously asserting, grants alternate I, D, I, D… Worst-case wait for a ready requester is 12 cycles.

## Test plan
- Reset, then single fetch:
  - Stimulus: mem[0x10..0x13] = 0x12, 0x34, 0x56, 0x78; if_req with if_addr=0x10.
  - Response: mem_addr 0x10→0x13 on cycles 1–4; if_ack on cycle 5 only; if_data=0x12345678; dm_ack stays 0.
- Simultaneous requests after reset:
  - Stimulus: if_addr=0x0, dm_addr=0x100 (contents 0xDEADBEEF).
  - Response: instruction served first (ack cycle 5); data served second (dm_ack cycle 11, dm_data=0xDEADBEEF).
- Sustained contention:
  - Stimulus: both req held high for 4 transactions.
  - Response: grant order I, D, I, D; acks never overlap.
- Wrap and upper-bit masking:
  - Stimulus: dm_addr=0xABCDFFFE, bytes 0xAA, 0xBB at 0xFFFE/0xFFFF and 0xCC, 0xDD at 0x0000/0x0001.
  - Response: mem_addr sequence FFFE, FFFF, 0000, 0001; dm_data=0xAABBCCDD.
- Address change and request drop mid-transaction:
  - Stimulus: if_addr changed and if_req dropped on cycle 2.
  - Response: original address completes, if_ack still pulses on cycle 5, no second transaction.
- Reset asserted on cycle 3 of a read:
  - Response: busy=0 and mem_rd=0 immediately; no ack; if_data=0.
  - After release, a held request restarts with a full 5-cycle latency.
